// File: rtl/litepcie_cc_pkg.sv
// Shared definitions for the legacy-completion to AXIS CC adapter: header and
// descriptor field offsets, limits, and the descriptor builder.
package litepcie_cc_pkg;

  localparam int CC_DESC_DW = 3;
  localparam int MAX_DWCNT  = 1024;
  localparam int MAX_BC     = 4096;

  // Legacy 3DW completion header, bit offsets within the 96-bit header.
  localparam int LG_LEN_LSB     = 0;
  localparam int LG_ATTR_LSB    = 12;
  localparam int LG_EP_BIT      = 14;
  localparam int LG_TC_LSB      = 20;
  localparam int LG_TYPE0_BIT   = 24;
  localparam int LG_FMT1_BIT    = 30;
  localparam int LG_BC_LSB      = 32;
  localparam int LG_STATUS_LSB  = 45;
  localparam int LG_CPLID_LSB   = 48;
  localparam int LG_LOWADDR_LSB = 64;
  localparam int LG_TAG_LSB     = 72;
  localparam int LG_REQID_LSB   = 80;

  // CC descriptor, bit offsets within the 96-bit descriptor.
  localparam int CC_LOWADDR_LSB = 0;
  localparam int CC_BC_LSB      = 16;
  localparam int CC_LOCKED_BIT  = 29;
  localparam int CC_DWCNT_LSB   = 32;
  localparam int CC_STATUS_LSB  = 43;
  localparam int CC_POISON_BIT  = 46;
  localparam int CC_REQID_LSB   = 48;
  localparam int CC_TAG_LSB     = 64;
  localparam int CC_CPLID_LSB   = 72;
  localparam int CC_TC_LSB      = 89;
  localparam int CC_ATTR_LSB    = 92;

  typedef enum logic {
    ST_SOP  = 1'b0,
    ST_BODY = 1'b1
  } beat_state_e;

  function automatic logic [95:0] build_cc_desc(input logic [95:0] hdr, input logic err_fwd);
    logic [95:0] desc;
    logic [9:0]  len;
    logic [11:0] bc;
    desc = 96'd0;
    len  = hdr[LG_LEN_LSB +: 10];
    bc   = hdr[LG_BC_LSB +: 12];
    desc[CC_LOWADDR_LSB +: 7] = hdr[LG_LOWADDR_LSB +: 7];
    if (bc == 12'd0) begin
      desc[CC_BC_LSB +: 13] = 13'(MAX_BC);
    end else begin
      desc[CC_BC_LSB +: 13] = {1'b0, bc};
    end
    desc[CC_LOCKED_BIT] = hdr[LG_TYPE0_BIT];
    // Cpl/CplLk carry no data regardless of the length field.
    if (!hdr[LG_FMT1_BIT]) begin
      desc[CC_DWCNT_LSB +: 11] = 11'd0;
    end else if (len == 10'd0) begin
      desc[CC_DWCNT_LSB +: 11] = 11'(MAX_DWCNT);
    end else begin
      desc[CC_DWCNT_LSB +: 11] = {1'b0, len};
    end
    desc[CC_STATUS_LSB +: 3] = hdr[LG_STATUS_LSB +: 3];
    desc[CC_POISON_BIT]      = hdr[LG_EP_BIT] | err_fwd;
    desc[CC_REQID_LSB +: 16] = hdr[LG_REQID_LSB +: 16];
    desc[CC_TAG_LSB +: 8]    = hdr[LG_TAG_LSB +: 8];
    desc[CC_CPLID_LSB +: 16] = hdr[LG_CPLID_LSB +: 16];
    desc[CC_TC_LSB +: 3]     = hdr[LG_TC_LSB +: 3];
    desc[CC_ATTR_LSB +: 3]   = {1'b0, hdr[LG_ATTR_LSB +: 2]};
    return desc;
  endfunction

endpackage

// File: rtl/s_axis_cc_adapt_x8_skid.sv
// Two-entry skid buffer with registered ready/valid/data; head entry drives the
// output directly so a stalled beat stays stable.
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem0_q, mem0_d;
  logic [W-1:0] mem1_q, mem1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         rdy_q, rdy_d;
  logic         vld_q, vld_d;
  logic         push_s, pop_s;

  // Occupancy update; ready is derived from the next occupancy so it is a flop.
  always_comb begin
    push_s = in_valid & rdy_q;
    pop_s  = vld_q & out_ready;
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push_s) begin
          mem0_d = in_data;
          cnt_d  = 2'd1;
        end else begin
          cnt_d  = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          mem0_d = in_data;
        end else if (push_s) begin
          mem1_d = in_data;
          cnt_d  = 2'd2;
        end else if (pop_s) begin
          cnt_d  = 2'd0;
        end else begin
          cnt_d  = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          mem0_d = mem1_q;
          cnt_d  = 2'd1;
        end else begin
          cnt_d  = 2'd2;
        end
      end
      default: cnt_d = 2'd0;
    endcase
    rdy_d = (cnt_d != 2'd2);
    vld_d = (cnt_d != 2'd0);
  end

  // State registers; storage needs no reset since it is qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      vld_q <= vld_d;
    end
    mem0_q <= mem0_d;
    mem1_q <= mem1_d;
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_data  = mem0_q;

endmodule

// File: rtl/s_axis_cc_adapt_x8.sv
// Legacy 3DW completion TLP stream to 256-bit AXIS CC descriptor format, with a
// payload length check that marks short/long packets as discontinued.
module s_axis_cc_adapt_x8
  import litepcie_cc_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                     user_clk,
  input  logic                     user_reset,
  input  logic [DATA_WIDTH-1:0]    s_axis_cc_tdata,
  input  logic [KEEP_WIDTH-1:0]    s_axis_cc_tkeep,
  input  logic                     s_axis_cc_tlast,
  input  logic [3:0]               s_axis_cc_tuser,
  input  logic                     s_axis_cc_tvalid,
  output logic                     s_axis_cc_tready,
  output logic [DATA_WIDTH-1:0]    s_axis_cc_tdata_a,
  output logic [DATA_WIDTH/32-1:0] s_axis_cc_tkeep_a,
  output logic                     s_axis_cc_tlast_a,
  output logic [32:0]              s_axis_cc_tuser_a,
  output logic                     s_axis_cc_tvalid_a,
  input  logic [3:0]               s_axis_cc_tready_a,
  output logic                     cc_len_err
);

  localparam int NDW = DATA_WIDTH / 32;
  localparam int PW  = DATA_WIDTH + NDW + 2;

  beat_state_e           state_q, state_d;
  logic [10:0]           cnt_q, cnt_d;
  logic [10:0]           exp_q, exp_d;
  logic                  len_err_q, len_err_d;

  logic                  accept_s;
  logic                  skid_ready_s;
  logic [NDW-1:0]        keep_a_s;
  logic [3:0]            pcnt_s;
  logic [11:0]           sum_s;
  logic [10:0]           total_s;
  logic [95:0]           desc_s;
  logic [10:0]           exp_cnt_s;
  logic                  mismatch_s;
  logic                  disc_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic [PW-1:0]         push_pl_s;
  logic [PW-1:0]         pop_pl_s;
  logic                  unused_ok_s;

  // Beat conversion, dword accounting and next-state logic.
  always_comb begin
    accept_s = s_axis_cc_tvalid & skid_ready_s;
    keep_a_s = '0;
    pcnt_s   = 4'd0;
    for (int i = 0; i < NDW; i++) begin
      keep_a_s[i] = s_axis_cc_tkeep[4*i];
      pcnt_s      = pcnt_s + {3'b000, s_axis_cc_tkeep[4*i]};
    end
    sum_s = {1'b0, cnt_q} + {8'd0, pcnt_s};
    if (sum_s > 12'd2047) begin
      total_s = 11'h7FF;
    end else begin
      total_s = sum_s[10:0];
    end

    desc_s = build_cc_desc(s_axis_cc_tdata[95:0], s_axis_cc_tuser[1]);
    data_s = s_axis_cc_tdata;
    if (state_q == ST_SOP) begin
      data_s[95:0] = desc_s;
      exp_cnt_s    = desc_s[CC_DWCNT_LSB +: 11];
    end else begin
      data_s[95:0] = s_axis_cc_tdata[95:0];
      exp_cnt_s    = exp_q;
    end

    // Accumulated count still includes the three header dwords.
    mismatch_s = ({1'b0, total_s} != ({1'b0, exp_cnt_s} + 12'(CC_DESC_DW)));
    disc_s     = s_axis_cc_tlast & mismatch_s;
    push_pl_s  = {data_s, keep_a_s, s_axis_cc_tlast, disc_s};

    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    len_err_d = 1'b0;
    if (accept_s) begin
      exp_d = exp_cnt_s;
      if (s_axis_cc_tlast) begin
        state_d   = ST_SOP;
        cnt_d     = 11'd0;
        len_err_d = mismatch_s;
      end else begin
        state_d   = ST_BODY;
        cnt_d     = total_s;
        len_err_d = 1'b0;
      end
    end else begin
      len_err_d = 1'b0;
    end
  end

  // Beat FSM, dword counter and error pulse.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q   <= ST_SOP;
      cnt_q     <= 11'd0;
      exp_q     <= 11'd0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      len_err_q <= len_err_d;
    end
  end

  axis_skid_buffer #(
    .W(PW)
  ) u_skid (
    .clk      (user_clk),
    .rst      (user_reset),
    .in_data  (push_pl_s),
    .in_valid (s_axis_cc_tvalid),
    .in_ready (skid_ready_s),
    .out_data (pop_pl_s),
    .out_valid(s_axis_cc_tvalid_a),
    .out_ready(s_axis_cc_tready_a[0])
  );

  assign s_axis_cc_tready  = skid_ready_s;
  assign s_axis_cc_tdata_a = pop_pl_s[PW-1 -: DATA_WIDTH];
  assign s_axis_cc_tkeep_a = pop_pl_s[2 +: NDW];
  assign s_axis_cc_tlast_a = pop_pl_s[1];
  assign s_axis_cc_tuser_a = {32'd0, pop_pl_s[0]};
  assign cc_len_err        = len_err_q;

  assign unused_ok_s = ^{s_axis_cc_tkeep, s_axis_cc_tuser, s_axis_cc_tready_a};

endmodule

// File: tb/tb_s_axis_cc_adapt_x8.sv
// Directed + randomized bench for s_axis_cc_adapt_x8 with a packet-level
// reference model and an output scoreboard.
module tb_s_axis_cc_adapt_x8;

  logic         clk = 1'b0;
  logic         user_reset;
  logic [255:0] tdata;
  logic [31:0]  tkeep;
  logic         tlast;
  logic [3:0]   tuser;
  logic         tvalid;
  logic         tready;
  logic [255:0] tdata_a;
  logic [7:0]   tkeep_a;
  logic         tlast_a;
  logic [32:0]  tuser_a;
  logic         tvalid_a;
  logic [3:0]   tready_a;
  logic         cc_len_err;

  always #5 clk = ~clk;

  s_axis_cc_adapt_x8 dut (
    .user_clk          (clk),
    .user_reset        (user_reset),
    .s_axis_cc_tdata   (tdata),
    .s_axis_cc_tkeep   (tkeep),
    .s_axis_cc_tlast   (tlast),
    .s_axis_cc_tuser   (tuser),
    .s_axis_cc_tvalid  (tvalid),
    .s_axis_cc_tready  (tready),
    .s_axis_cc_tdata_a (tdata_a),
    .s_axis_cc_tkeep_a (tkeep_a),
    .s_axis_cc_tlast_a (tlast_a),
    .s_axis_cc_tuser_a (tuser_a),
    .s_axis_cc_tvalid_a(tvalid_a),
    .s_axis_cc_tready_a(tready_a),
    .cc_len_err        (cc_len_err)
  );

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic [3:0]   user;
  } ibeat_t;

  typedef struct {
    logic [255:0] data;
    logic [7:0]   keep;
    logic         last;
    logic         disc;
  } obeat_t;

  ibeat_t in_q[$];
  obeat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int len_err_seen = 0;
  int len_err_exp = 0;

  wire [297:0] out_bus = {tdata_a, tkeep_a, tlast_a, tuser_a};
  logic [297:0] snap = '0;
  logic prev_stall = 1'b0;
  logic prev_lerr = 1'b0;

  // Scoreboard: every handshaken output beat against the model queue.
  always @(negedge clk) begin
    obeat_t e;
    if (cc_len_err === 1'b1) len_err_seen++;
    if (prev_lerr) begin
      checks++;
      assert (cc_len_err === 1'b0) else begin
        errors++; $error("FAIL len_err_width obs=%b exp=0", cc_len_err);
      end
    end
    if (prev_stall && tvalid_a === 1'b1) begin
      checks++;
      assert (out_bus === snap) else begin
        errors++; $error("FAIL stall_stable obs=%h exp=%h", out_bus, snap);
      end
    end
    if (tvalid_a === 1'b1 && tready_a[0] === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++; $error("FAIL unexpected_beat obs=%h exp=none", out_bus);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (out_bus === {e.data, e.keep, e.last, 32'd0, e.disc}) else begin
          errors++;
          $error("FAIL out_beat obs=%h exp=%h", out_bus, {e.data, e.keep, e.last, 32'd0, e.disc});
        end
      end
    end
    prev_stall = (tvalid_a === 1'b1) && (tready_a[0] === 1'b0);
    prev_lerr  = (cc_len_err === 1'b1);
    snap       = out_bus;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  // Builds legacy beats and, if record=1, the expected CC beats from header fields.
  task automatic make_pkt(input bit fmt_data, input bit lk, input int len, input int bc,
                          input int status, input bit ep, input bit poison, input int tag,
                          input int lowaddr, input int n_pl, input bit record);
    logic [31:0] h0, h1, h2;
    logic [15:0] req_id, cpl_id;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [95:0] desc;
    int dwcnt, bcf, total, nb, nd;
    bit mism;
    ibeat_t ib;
    obeat_t ob;
    req_id = 16'($urandom);
    cpl_id = 16'($urandom);
    tc     = 3'($urandom);
    attr   = 2'($urandom);
    h0 = 32'(len & 1023) | (32'(attr) << 12) | (32'(ep) << 14) | (32'($urandom_range(0, 1)) << 15)
       | (32'(tc) << 20) | (32'(lk ? 11 : 10) << 24) | ((fmt_data ? 32'd2 : 32'd0) << 29);
    h1 = 32'(bc & 4095) | (32'($urandom_range(0, 1)) << 12) | (32'(status & 7) << 13) | (32'(cpl_id) << 16);
    h2 = 32'(lowaddr & 127) | (32'($urandom_range(0, 1)) << 7) | (32'(tag & 255) << 8) | (32'(req_id) << 16);
    bcf   = (bc == 0) ? 4096 : bc;
    dwcnt = fmt_data ? ((len == 0) ? 1024 : len) : 0;
    desc[31:0]  = 32'(lowaddr & 127) | (32'(bcf) << 16) | (32'(lk) << 29);
    desc[63:32] = 32'(dwcnt) | (32'(status & 7) << 11) | (32'(ep | poison) << 14) | (32'(req_id) << 16);
    desc[95:64] = 32'(tag & 255) | (32'(cpl_id) << 8) | (32'(tc) << 25) | (32'(attr) << 28);
    mism  = (n_pl != dwcnt);
    if (record && mism) len_err_exp++;
    total = 3 + n_pl;
    nb    = (total + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      nd = total - 8 * b;
      if (nd > 8) nd = 8;
      ib.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (b == 0) ib.data[95:0] = {h2, h1, h0};
      ib.keep = '0;
      ob.keep = '0;
      for (int j = 0; j < nd; j++) begin
        ib.keep[4*j +: 4] = 4'hF;
        ob.keep[j] = 1'b1;
      end
      ib.last    = (b == nb - 1);
      ib.user    = 4'($urandom);
      ib.user[1] = poison;
      in_q.push_back(ib);
      ob.data = ib.data;
      if (b == 0) ob.data[95:0] = desc;
      ob.last = ib.last;
      ob.disc = ib.last && mism;
      if (record) exp_q.push_back(ob);
    end
  endtask

  // Drives up to n queued beats; returns the number of cycles spent waiting on ready.
  task automatic send_n(input int n, input bit gaps, output int stalls);
    ibeat_t b;
    bit acc;
    int guard;
    stalls = 0;
    for (int k = 0; k < n && in_q.size() > 0; k++) begin
      b = in_q.pop_front();
      if (gaps && $urandom_range(0, 3) == 0) begin
        tvalid = 1'b0;
        @(posedge clk); #1;
      end
      tdata = b.data; tkeep = b.keep; tlast = b.last; tuser = b.user; tvalid = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 500) begin
        @(negedge clk);
        acc = (tready === 1'b1);
        @(posedge clk); #1;
        if (!acc) stalls++;
        guard++;
      end
      checks++;
      assert (acc === 1'b1) else begin
        errors++; $error("FAIL send_timeout obs=%b exp=1", acc);
      end
    end
    tvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 4000) begin
      @(posedge clk);
      g++;
    end
    @(posedge clk); #1;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++; $error("FAIL %s_drain obs=%0d exp=0", tag, exp_q.size());
    end
    checks++;
    assert (len_err_seen == len_err_exp) else begin
      errors++; $error("FAIL %s_len_err_count obs=%0d exp=%0d", tag, len_err_seen, len_err_exp);
    end
  endtask

  initial begin
    int st;
    bit fd;
    int l;
    user_reset = 1'b1;
    tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; tuser = '0;
    tready_a = 4'b0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; assert (tvalid_a === 1'b0) else begin errors++; $error("FAIL rst_tvalid_a obs=%b exp=0", tvalid_a); end
    checks++; assert (tready === 1'b0) else begin errors++; $error("FAIL rst_tready obs=%b exp=0", tready); end
    checks++; assert (cc_len_err === 1'b0) else begin errors++; $error("FAIL rst_len_err obs=%b exp=0", cc_len_err); end
    @(posedge clk); #1;
    user_reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; assert (tready === 1'b1) else begin errors++; $error("FAIL post_rst_tready obs=%b exp=1", tready); end
    @(posedge clk); #1;

    // Single-beat CplD, one-cycle latency.
    make_pkt(1'b1, 1'b0, 1, 4, 0, 1'b0, 1'b0, 8'h5A, 7'h04, 1, 1'b1);
    send_n(1, 1'b0, st);
    @(negedge clk);
    checks++; assert (tvalid_a === 1'b1) else begin errors++; $error("FAIL single_latency obs=%b exp=1", tvalid_a); end
    checks++; assert (tdata_a[31:0] === 32'h0004_0004) else begin errors++; $error("FAIL single_dw0 obs=%h exp=00040004", tdata_a[31:0]); end
    checks++; assert (tdata_a[42:32] === 11'd1) else begin errors++; $error("FAIL single_dwcnt obs=%h exp=1", tdata_a[42:32]); end
    checks++; assert (tkeep_a === 8'h0F) else begin errors++; $error("FAIL single_keep obs=%h exp=0f", tkeep_a); end
    checks++; assert (st == 0) else begin errors++; $error("FAIL single_stalls obs=%0d exp=0", st); end
    drain("single");

    // 16 DW CplD at full throughput.
    make_pkt(1'b1, 1'b0, 16, 64, 0, 1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 127), 16, 1'b1);
    send_n(1000, 1'b0, st);
    checks++; assert (st == 0) else begin errors++; $error("FAIL thru_stalls obs=%0d exp=0", st); end
    drain("cpld16");

    // Cpl without data, status UR.
    make_pkt(1'b0, 1'b0, 5, 12, 1, 1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 127), 0, 1'b1);
    send_n(1000, 1'b0, st);
    drain("cpl_ur");

    // Length mismatch: 8 expected, 7 sent.
    make_pkt(1'b1, 1'b0, 8, 32, 0, 1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 127), 7, 1'b1);
    send_n(1000, 1'b0, st);
    @(negedge clk);
    checks++; assert (cc_len_err === 1'b1) else begin errors++; $error("FAIL mism_pulse obs=%b exp=1", cc_len_err); end
    checks++; assert (tuser_a[0] === 1'b1) else begin errors++; $error("FAIL mism_disc obs=%b exp=1", tuser_a[0]); end
    @(negedge clk);
    checks++; assert (cc_len_err === 1'b0) else begin errors++; $error("FAIL mism_pulse_end obs=%b exp=0", cc_len_err); end
    @(posedge clk); #1;
    make_pkt(1'b1, 1'b1, 12, 48, 0, 1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 127), 12, 1'b1);
    send_n(1000, 1'b1, st);
    drain("mism");

    // Boundary: byte count 0, length 0 -> 4096 bytes, 1024 DW.
    make_pkt(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1, $urandom_range(0, 255), $urandom_range(0, 127), 1024, 1'b1);
    send_n(1000, 1'b1, st);
    drain("max");

    // Randomized well-formed packets.
    for (int p = 0; p < 6; p++) begin
      fd = 1'($urandom_range(0, 1));
      l  = $urandom_range(1, 40);
      make_pkt(fd, 1'($urandom_range(0, 1)), l, $urandom_range(0, 4095), $urandom_range(0, 7),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 255),
               $urandom_range(0, 127), fd ? l : 0, 1'b1);
      send_n(1000, 1'b1, st);
    end
    drain("rand");

    // Backpressure: ready toggles 1-0 during a 32 DW packet.
    make_pkt(1'b1, 1'b0, 32, 128, 0, 1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 127), 32, 1'b1);
    fork
      send_n(1000, 1'b0, st);
      begin
        for (int i = 0; i < 24; i++) begin
          tready_a = (i % 2 == 0) ? 4'b1011 : 4'b1110;
          @(posedge clk); #1;
        end
      end
    join
    tready_a = 4'b0001;
    checks++; assert (st > 0) else begin errors++; $error("FAIL bp_ready_drop obs=%0d exp=>0", st); end
    drain("bp");

    // Reset in the middle of a packet held in a stalled buffer.
    tready_a = 4'b0000;
    make_pkt(1'b1, 1'b0, 20, 80, 0, 1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 127), 20, 1'b0);
    send_n(2, 1'b0, st);
    in_q.delete();
    user_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; assert (tvalid_a === 1'b0) else begin errors++; $error("FAIL midrst_tvalid obs=%b exp=0", tvalid_a); end
    checks++; assert (tready === 1'b0) else begin errors++; $error("FAIL midrst_tready obs=%b exp=0", tready); end
    @(posedge clk); #1;
    user_reset = 1'b0;
    tready_a = 4'b0001;
    @(negedge clk);
    checks++; assert (tvalid_a === 1'b0) else begin errors++; $error("FAIL postrst_tvalid obs=%b exp=0", tvalid_a); end
    @(posedge clk); #1;
    make_pkt(1'b1, 1'b0, 9, 36, 2, 1'b1, 1'b0, $urandom_range(0, 255), $urandom_range(0, 127), 9, 1'b1);
    send_n(1000, 1'b1, st);
    drain("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
